wash_panel_ctrl: RTL and testbench



---
 rtl/wash_panel_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_wash_panel_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_panel_ctrl.sv
// Washing-machine front panel: conditions raw buttons and the door switch, latches the
// program selection and sequences the door-lock / start / pause handshake to the sequencer.
module wash_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCK_CYCLES     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_double,
  input  logic btn_dry,
  input  logic btn_stop,
  input  logic door_closed,
  input  logic machine_done,
  output logic start,
  output logic double_wash,
  output logic dry_wash,
  output logic stop,
  output logic door_lock,
  output logic busy,
  output logic door_err
);

  localparam int NIN = 5;
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LCW-1:0] LOCK_LOAD = LCW'(LOCK_CYCLES);

  typedef enum logic [2:0] {
    IDLE_SEL  = 3'd0,
    LOCKING   = 3'd1,
    RUN       = 3'd2,
    PAUSED    = 3'd3,
    UNLOCKING = 3'd4
  } state_t;

  // Bit order: 0 start, 1 double, 2 dry, 3 stop, 4 door
  logic [NIN-1:0] raw_s;
  logic [NIN-1:0] sync1_r;
  logic [NIN-1:0] sync2_r;
  logic [NIN-1:0] deb_r;
  logic [3:0]     deb_d_r;
  logic [3:0]     press_r;
  logic [DCW-1:0] db_cnt_r [NIN];

  state_t         state_r;
  logic [LCW-1:0] lock_cnt_r;
  logic           start_r;
  logic           double_r;
  logic           dry_r;
  logic           stop_r;
  logic           lock_r;
  logic           busy_r;
  logic           err_r;

  logic press_start_s;
  logic press_double_s;
  logic press_dry_s;
  logic press_stop_s;
  logic door_ok_s;

  assign raw_s          = {door_closed, btn_stop, btn_dry, btn_double, btn_start};
  assign press_start_s  = press_r[0];
  assign press_double_s = press_r[1];
  assign press_dry_s    = press_r[2];
  assign press_stop_s   = press_r[3];
  assign door_ok_s      = deb_r[4];

  // Synchronise, debounce and edge-detect every raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {NIN{1'b0}};
      sync2_r <= {NIN{1'b0}};
      deb_r   <= {NIN{1'b0}};
      deb_d_r <= 4'b0000;
      press_r <= 4'b0000;
      for (int i = 0; i < NIN; i++) begin
        db_cnt_r[i] <= {DCW{1'b0}};
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r[3:0];
      press_r <= deb_r[3:0] & ~deb_d_r;
      for (int i = 0; i < NIN; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          db_cnt_r[i] <= {DCW{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          deb_r[i]    <= sync2_r[i];
          db_cnt_r[i] <= {DCW{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DCW'(1);
        end
      end
    end
  end

  // Panel state machine; every output is a register written here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE_SEL;
      lock_cnt_r <= {LCW{1'b0}};
      start_r    <= 1'b0;
      double_r   <= 1'b0;
      dry_r      <= 1'b0;
      stop_r     <= 1'b0;
      lock_r     <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      start_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        IDLE_SEL: begin
          if (press_double_s) double_r <= ~double_r;
          if (press_dry_s)    dry_r    <= ~dry_r;
          if (press_start_s) begin
            if (door_ok_s) begin
              state_r    <= LOCKING;
              lock_r     <= 1'b1;
              busy_r     <= 1'b1;
              lock_cnt_r <= LOCK_LOAD;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        LOCKING: begin
          if (!door_ok_s) begin
            state_r <= IDLE_SEL;
            lock_r  <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b1;
          end else if (lock_cnt_r == {LCW{1'b0}}) begin
            state_r <= RUN;
            start_r <= 1'b1;
          end else begin
            lock_cnt_r <= lock_cnt_r - LCW'(1);
          end
        end
        RUN: begin
          if (machine_done) begin
            state_r    <= UNLOCKING;
            lock_cnt_r <= LOCK_LOAD;
          end else if (!door_ok_s) begin
            state_r <= PAUSED;
            stop_r  <= 1'b1;
            err_r   <= 1'b1;
          end else if (press_stop_s) begin
            state_r <= PAUSED;
            stop_r  <= 1'b1;
          end
        end
        PAUSED: begin
          if (machine_done) begin
            state_r    <= UNLOCKING;
            stop_r     <= 1'b0;
            lock_cnt_r <= LOCK_LOAD;
          end else if (press_start_s) begin
            if (door_ok_s) begin
              state_r <= RUN;
              stop_r  <= 1'b0;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        UNLOCKING: begin
          if (lock_cnt_r == {LCW{1'b0}}) begin
            state_r  <= IDLE_SEL;
            lock_r   <= 1'b0;
            busy_r   <= 1'b0;
            double_r <= 1'b0;
            dry_r    <= 1'b0;
          end else begin
            lock_cnt_r <= lock_cnt_r - LCW'(1);
          end
        end
        default: begin
          state_r <= IDLE_SEL;
          stop_r  <= 1'b0;
          lock_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign start       = start_r;
  assign double_wash = double_r;
  assign dry_wash    = dry_r;
  assign stop        = stop_r;
  assign door_lock   = lock_r;
  assign busy        = busy_r;
  assign door_err    = err_r;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Bench for wash_panel_ctrl: directed stimulus, a history-based behavioural model checked
// every cycle, and hand-computed latency/count checks.
module tb_wash_panel_ctrl;

  localparam int D    = 4;
  localparam int L    = 3;
  localparam int MAXC = 4096;
  localparam int PH_IDLE = 0, PH_LOCK = 1, PH_RUN = 2, PH_PAUSE = 3, PH_UNLOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0, btn_double = 1'b0, btn_dry = 1'b0, btn_stop = 1'b0;
  logic door_closed = 1'b0, machine_done = 1'b0;
  logic start, double_wash, dry_wash, stop, door_lock, busy, door_err;

  always #5 clk = ~clk;

  wash_panel_ctrl #(.DEBOUNCE_CYCLES(D), .LOCK_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_double(btn_double),
    .btn_dry(btn_dry), .btn_stop(btn_stop), .door_closed(door_closed),
    .machine_done(machine_done), .start(start), .double_wash(double_wash),
    .dry_wash(dry_wash), .stop(stop), .door_lock(door_lock), .busy(busy),
    .door_err(door_err)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = -1, rst_edge = -1;
  int err_seen = 0, start_seen = 0;
  logic [4:0] raw_h [MAXC];
  logic [4:0] deb_h [MAXC];
  int phase = PH_IDLE, left = 0;
  bit m_start = 1'b0, m_dbl = 1'b0, m_dry = 1'b0, m_err = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Samples taken during or before the latest reset count as 0
  function automatic logic [4:0] raw_at(input int k);
    if (k < 0 || k <= rst_edge || k >= MAXC) return 5'b00000;
    return raw_h[k];
  endfunction

  function automatic logic [4:0] deb_at(input int k);
    if (k < 0 || k <= rst_edge || k >= MAXC) return 5'b00000;
    return deb_h[k];
  endfunction

  // A debounced level flips once the last D synchronised samples all disagree with it;
  // the FSM sees presses two edges after the debounced rise and the door one edge after.
  task automatic model_step();
    int j;
    logic [4:0] prev, nd, smp, rose;
    bit run, door;
    j = cyc;
    if (j >= MAXC) return;
    raw_h[j] = {door_closed, btn_stop, btn_dry, btn_double, btn_start};
    m_start = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      rst_edge = j;
      deb_h[j] = 5'b00000;
      phase = PH_IDLE; left = 0; m_dbl = 1'b0; m_dry = 1'b0;
      return;
    end
    prev = deb_at(j - 1);
    nd = prev;
    for (int i = 0; i < 5; i++) begin
      run = 1'b1;
      for (int m = 0; m < D; m++) begin
        smp = raw_at(j - 2 - m);
        if (smp[i] == prev[i]) run = 1'b0;
      end
      if (run) nd[i] = ~prev[i];
    end
    deb_h[j] = nd;
    rose = deb_at(j - 2) & ~deb_at(j - 3);
    door = prev[4];
    case (phase)
      PH_IDLE: begin
        if (rose[1]) m_dbl = ~m_dbl;
        if (rose[2]) m_dry = ~m_dry;
        if (rose[0]) begin
          if (door) begin phase = PH_LOCK; left = L + 1; end
          else m_err = 1'b1;
        end
      end
      PH_LOCK: begin
        if (!door) begin phase = PH_IDLE; m_err = 1'b1; end
        else begin
          left--;
          if (left == 0) begin phase = PH_RUN; m_start = 1'b1; end
        end
      end
      PH_RUN: begin
        if (machine_done) begin phase = PH_UNLOCK; left = L + 1; end
        else if (!door) begin phase = PH_PAUSE; m_err = 1'b1; end
        else if (rose[3]) phase = PH_PAUSE;
      end
      PH_PAUSE: begin
        if (machine_done) begin phase = PH_UNLOCK; left = L + 1; end
        else if (rose[0]) begin
          if (door) phase = PH_RUN;
          else m_err = 1'b1;
        end
      end
      default: begin
        left--;
        if (left == 0) begin phase = PH_IDLE; m_dbl = 1'b0; m_dry = 1'b0; end
      end
    endcase
  endtask

  // Model comparison on every cycle
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      chk("start", int'(start), int'(m_start));
      chk("double_wash", int'(double_wash), int'(m_dbl));
      chk("dry_wash", int'(dry_wash), int'(m_dry));
      chk("stop", int'(stop), int'(phase == PH_PAUSE));
      chk("door_lock", int'(door_lock), int'(phase != PH_IDLE));
      chk("busy", int'(busy), int'(phase != PH_IDLE));
      chk("door_err", int'(door_err), int'(m_err));
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (door_err) err_seen++;
      if (start) start_seen++;
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_start = v;
      1: btn_double = v;
      2: btn_dry = v;
      default: btn_stop = v;
    endcase
  endtask

  task automatic hold(input int idx, input int n);
    @(negedge clk);
    set_btn(idx, 1'b1);
    tick(n);
    @(negedge clk);
    set_btn(idx, 1'b0);
  endtask

  // which: 0 door_lock, 1 start; edge = -1 when the budget runs out
  task automatic wait_for(input int which, input logic val, input int budget, output int edge_o);
    edge_o = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if ((which == 0 && door_lock == val) || (which == 1 && start == val)) begin
        edge_o = cyc;
        return;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_double"}, int'(double_wash), 0);
    chk({tag, "_dry"}, int'(dry_wash), 0);
    chk({tag, "_stop"}, int'(stop), 0);
    chk({tag, "_lock"}, int'(door_lock), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(door_err), 0);
  endtask

  initial begin
    int e0, e1, e2;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    door_closed = 1'b1;
    tick(10);

    // Select double, then start: lock D+3 edges after the raw press, start L+1 edges later
    hold(1, 10);
    tick(8);
    chk("t1_double", int'(double_wash), 1);
    @(negedge clk);
    btn_start = 1'b1;
    e0 = cyc + 1;
    start_seen = 0;
    wait_for(0, 1'b1, 20, e1);
    chk("t1_lock_latency", e1 - e0, 7);
    wait_for(1, 1'b1, 20, e2);
    chk("t1_start_latency", e2 - e1, 4);
    chk("t1_busy", int'(busy), 1);
    @(negedge clk);
    btn_start = 1'b0;
    tick(10);
    chk("t1_one_start", start_seen, 1);

    // Pause and resume without a new start pulse
    start_seen = 0;
    hold(3, 6);
    tick(8);
    chk("t3_stop", int'(stop), 1);
    hold(0, 6);
    tick(8);
    chk("t3_resume", int'(stop), 0);
    chk("t3_no_start", start_seen, 0);

    // Completion: lock released 4 edges after done, selections cleared with it
    @(negedge clk);
    machine_done = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    machine_done = 1'b0;
    wait_for(0, 1'b0, 20, e1);
    chk("t5_unlock_latency", e1 - e0, 4);
    chk("t5_double_clr", int'(double_wash), 0);
    chk("t5_busy", int'(busy), 0);

    // Dry glitch of D-1 cycles is rejected, D cycles is accepted
    hold(2, 3);
    tick(10);
    chk("t2_glitch", int'(dry_wash), 0);
    hold(2, 4);
    tick(10);
    chk("t2_dry", int'(dry_wash), 1);

    // Start with the door open is rejected with one error pulse
    @(negedge clk);
    door_closed = 1'b0;
    tick(10);
    err_seen = 0;
    hold(0, 6);
    tick(10);
    chk("t4_err_count", err_seen, 1);
    chk("t4_lock", int'(door_lock), 0);
    chk("t4_busy", int'(busy), 0);

    // Start and double in the same cycle: toggled selection goes with the run
    @(negedge clk);
    door_closed = 1'b1;
    tick(10);
    @(negedge clk);
    btn_double = 1'b1;
    btn_start = 1'b1;
    tick(6);
    @(negedge clk);
    btn_double = 1'b0;
    btn_start = 1'b0;
    wait_for(1, 1'b1, 20, e2);
    chk("sim_reached_run", int'(e2 >= 0), 1);
    chk("sim_double", int'(double_wash), 1);
    chk("sim_dry", int'(dry_wash), 1);

    // Door opens together with a stop press in RUN
    err_seen = 0;
    @(negedge clk);
    door_closed = 1'b0;
    btn_stop = 1'b1;
    tick(6);
    @(negedge clk);
    btn_stop = 1'b0;
    tick(10);
    chk("t6_stop", int'(stop), 1);
    chk("t6_err_count", err_seen, 1);
    err_seen = 0;
    hold(0, 6);
    tick(10);
    chk("t6_paused_open_err", err_seen, 1);
    chk("t6_still_paused", int'(stop), 1);

    // Resume, then reset in the middle of RUN
    @(negedge clk);
    door_closed = 1'b1;
    tick(10);
    hold(0, 6);
    tick(10);
    chk("t6_resumed", int'(stop), 0);
    chk("t6_locked", int'(door_lock), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midrun_rst");
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
